lemming_terrain: RTL
====================

# lemming_terrain

Terrain and position model that closes the loop around the lemming walker FSM. It consumes the walker's Moore outputs (walk_left, walk_right, aaah, digging) and produces that FSM's environment inputs (ground, bump_left, bump_right). It tracks the lemming's column on a 1-D strip of ground and wall tiles, removes ground under a digging lemming, and refills a pit once a fall completes. It also reports position, dig statistics and protocol errors to the bench and scoreboard.

## Interface
- WIDTH, 16, number of terrain columns (≥2); XW = $clog2(WIDTH)
- DIG_CYCLES, 4, consecutive digging cycles that remove one ground tile (≥1)
- FALL_CYCLES, 8, aaah cycles before the pit floor is reached (≥1)
- INIT_MAP, all ones, ground_map reset value
- clk  in  1  sole clock, rising edge
- areset_n  in  1  asynchronous, active-low reset
- load  in  1  synchronous load of world; highest priority
- map_in  in  WIDTH  ground bits for load (1 = solid)
- wall_in  in  WIDTH  wall bits for load (1 = wall column, not enterable)
- start_x  in  XW  start column for load; values >WIDTH-1 clamp to WIDTH-1
- walk_left, walk_right, aaah, digging  in  1 each  walker FSM state outputs
- ground  out  1  solid floor under lemming
- bump_left, bump_right  out  1 each  blocked in current walk direction
- pos  out  XW  current column
- tiles_dug  out  8  tiles removed, saturating at 255
- err  out  1  sticky protocol error

## Operation
- State registers: ground_map[WIDTH], wall_map[WIDTH], x[XW], dig_cnt, fall_cnt, tiles_dug, err.
- Reset values: ground_map=INIT_MAP, wall_map=0, x=0, dig_cnt=0, fall_cnt=0, tiles_dug=0, err=0.
- Priority per edge: load > fall > dig > move.
- load=1 writes ground_map=map_in, wall_map=wall_in, x=clamp(start_x). It clears dig_cnt, fall_cnt, tiles_dug and err. All walker inputs are ignored that cycle.
- Outputs are combinational from registers plus the current walker inputs (walker outputs are Moore, so no loop):
  - ground = ground_map[x]
  - bump_left = walk_left & (x==0 | wall_map[x-1])
  - bump_right = walk_right & (x==WIDTH-1 | wall_map[x+1])
  - pos = x
- Move:
  - walk_left & !bump_left → x-1.
  - walk_right & !bump_right → x+1.
  - Bumped → x holds.
- Dig, while digging=1 and ground=1:
  - If dig_cnt==DIG_CYCLES-1: clear ground_map[x], set dig_cnt=0, tiles_dug+1 (saturating).
  - Otherwise dig_cnt+1.
  - digging=0 clears dig_cnt. A dig interrupted before completion leaves the tile intact.
- Fall, while aaah=1 and ground=0:
  - If fall_cnt==FALL_CYCLES-1: set ground_map[x]=1 (pit refilled, lemming lands), fall_cnt=0.
  - Otherwise fall_cnt+1.
  - aaah=0 clears fall_cnt.
- Walking into a column with ground_map=0 drops ground the following cycle; the walker then falls.
- err sets and holds until load or reset on any of:
  - more than one of walk_left, walk_right, aaah, digging high in a cycle
  - walk_* high while ground=0
  - aaah high while ground=1 for 2 consecutive cycles
- In any err-causing cycle, x, ground_map and all counters hold.

## Timing
- Movement, dig completion and landing take effect at the clock edge. Outputs reflect them in the same cycle after that edge (zero additional latency).
- Tile removal: ground falls on the cycle after the DIG_CYCLES-th consecutive digging cycle.
- Landing: ground rises on the cycle after the FALL_CYCLES-th consecutive aaah cycle with ground=0.
- Reset mid-dig or mid-fall: everything returns to reset values immediately (async). Partial dig and fall progress is lost.
- load during a fall or dig aborts it and clears the counters. The new world is visible the next cycle.
- tiles_dug at 255 stays 255.

## Test plan
- Reset, then walk_left=1 at x=0 → bump_left=1, pos stays 0. Then walk_right=1 for 3 cycles → pos=3, bump_right=0.
- Load wall_in bit 5=1, start_x=3; walk_right → pos=4, then bump_right=1 and pos holds at 4 for 5 cycles.
- Load map_in bit 2=0, start_x=0; walk_right 2 cycles → pos=2, ground=0. aaah for 8 cycles → ground returns to 1 and ground_map[2]=1.
- At x=6, digging=1 for 3 cycles then 0 → ground stays 1, tiles_dug=0. Then digging=1 for 4 cycles → ground=0, tiles_dug=1.
- walk_left and walk_right both high for 1 cycle → err=1, pos unchanged. err stays 1 until load pulse → err=0.
- Assert areset_n=0 at fall_cnt=5 → ground=INIT_MAP[0]=1, pos=0, err=0 asynchronously, before the next edge.

Source files
------------

// File: rtl/lemming_terrain.sv
// Purpose: 1-D terrain and position model that closes the loop around the lemming walker FSM.
// Latency: moves, digs and landings commit at the clock edge; outputs are combinational from the registers.
// Backpressure: none. Walker inputs are sampled every cycle, and any protocol violation freezes the world and sets err.
//
// Ports:
//   clk, areset_n            rising-edge clock, asynchronous active-low reset
//   load, map_in, wall_in,   synchronous world load (highest priority); start_x
//   start_x                  is clamped to WIDTH-1
//   walk_left, walk_right,   walker FSM Moore state outputs
//   aaah, digging
//   ground, bump_left,       walker FSM environment inputs
//   bump_right
//   pos, tiles_dug, err      current column, saturating dig count, sticky protocol error
module lemming_terrain #(
    parameter int              WIDTH       = 16,
    parameter int              DIG_CYCLES  = 4,
    parameter int              FALL_CYCLES = 8,
    parameter logic [WIDTH-1:0] INIT_MAP   = '1,
    localparam int             XW          = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic             clk,
    input  logic             areset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] map_in,
    input  logic [WIDTH-1:0] wall_in,
    input  logic [XW-1:0]    start_x,
    input  logic             walk_left,
    input  logic             walk_right,
    input  logic             aaah,
    input  logic             digging,
    output logic             ground,
    output logic             bump_left,
    output logic             bump_right,
    output logic [XW-1:0]    pos,
    output logic [7:0]       tiles_dug,
    output logic             err
);

    localparam int DCW = (DIG_CYCLES  > 1) ? $clog2(DIG_CYCLES)  : 1;
    localparam int FCW = (FALL_CYCLES > 1) ? $clog2(FALL_CYCLES) : 1;

    localparam logic [XW-1:0]  X_MAX    = XW'(WIDTH - 1);
    localparam logic [DCW-1:0] DIG_LAST = DCW'(DIG_CYCLES - 1);
    localparam logic [FCW-1:0] FALL_LAST = FCW'(FALL_CYCLES - 1);

    logic [WIDTH-1:0] ground_map_q, ground_map_d;
    logic [WIDTH-1:0] wall_map_q,   wall_map_d;
    logic [XW-1:0]    x_q,          x_d;
    logic [DCW-1:0]   dig_cnt_q,    dig_cnt_d;
    logic [FCW-1:0]   fall_cnt_q,   fall_cnt_d;
    logic [7:0]       tiles_dug_q,  tiles_dug_d;
    logic             err_q,        err_d;
    // Remembers that the previous cycle had aaah high over solid ground. One
    // such cycle is legal (the walker sees ground one cycle after landing);
    // two in a row is a protocol error.
    logic             aaah_gnd_q,   aaah_gnd_d;

    logic          ground_cur;
    logic          at_left;
    logic          at_right;
    logic          blocked_l;
    logic          blocked_r;
    logic          multi_hot;
    logic          walk_no_gnd;
    logic          aaah_on_gnd;
    logic          err_hit;
    logic [XW-1:0] start_clamped;

    // start_x can only exceed WIDTH-1 when WIDTH is not a power of two.
    generate
        if (WIDTH == (1 << XW)) begin : g_no_clamp
            assign start_clamped = start_x;
        end else begin : g_clamp
            assign start_clamped = (start_x > X_MAX) ? X_MAX : start_x;
        end
    endgenerate

    always_comb begin
        ground_cur = ground_map_q[x_q];
        at_left    = (x_q == '0);
        at_right   = (x_q == X_MAX);
        // The edge of the strip acts as a wall; guarding the index keeps
        // x-1 / x+1 from wrapping into the opposite end.
        blocked_l  = at_left  ? 1'b1 : wall_map_q[x_q - 1'b1];
        blocked_r  = at_right ? 1'b1 : wall_map_q[x_q + 1'b1];
    end

    assign ground     = ground_cur;
    assign bump_left  = walk_left  & blocked_l;
    assign bump_right = walk_right & blocked_r;
    assign pos        = x_q;
    assign tiles_dug  = tiles_dug_q;
    assign err        = err_q;

    always_comb begin
        multi_hot   = ($countones({walk_left, walk_right, aaah, digging}) > 1);
        walk_no_gnd = (walk_left | walk_right) & ~ground_cur;
        aaah_on_gnd = aaah & ground_cur;
        err_hit     = multi_hot | walk_no_gnd | (aaah_on_gnd & aaah_gnd_q);
    end

    always_comb begin
        ground_map_d = ground_map_q;
        wall_map_d   = wall_map_q;
        x_d          = x_q;
        dig_cnt_d    = dig_cnt_q;
        fall_cnt_d   = fall_cnt_q;
        tiles_dug_d  = tiles_dug_q;
        err_d        = err_q;
        aaah_gnd_d   = aaah_on_gnd;

        if (load) begin
            ground_map_d = map_in;
            wall_map_d   = wall_in;
            x_d          = start_clamped;
            dig_cnt_d    = '0;
            fall_cnt_d   = '0;
            tiles_dug_d  = '0;
            err_d        = 1'b0;
            aaah_gnd_d   = 1'b0;
        end else if (err_hit) begin
            // Freeze position, terrain and counters on a bad cycle so the
            // scoreboard sees the world exactly as it was when things broke.
            err_d = 1'b1;
        end else begin
            // Progress counters only survive an uninterrupted run of their
            // own activity.
            dig_cnt_d  = '0;
            fall_cnt_d = '0;

            if (aaah && !ground_cur) begin
                if (fall_cnt_q == FALL_LAST) begin
                    ground_map_d[x_q] = 1'b1;
                end else begin
                    fall_cnt_d = fall_cnt_q + 1'b1;
                end
            end else if (digging && ground_cur) begin
                if (dig_cnt_q == DIG_LAST) begin
                    ground_map_d[x_q] = 1'b0;
                    if (tiles_dug_q != 8'hFF) begin
                        tiles_dug_d = tiles_dug_q + 8'd1;
                    end
                end else begin
                    dig_cnt_d = dig_cnt_q + 1'b1;
                end
            end else if (walk_left && !blocked_l) begin
                x_d = x_q - 1'b1;
            end else if (walk_right && !blocked_r) begin
                x_d = x_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            ground_map_q <= INIT_MAP;
            wall_map_q   <= '0;
            x_q          <= '0;
            dig_cnt_q    <= '0;
            fall_cnt_q   <= '0;
            tiles_dug_q  <= '0;
            err_q        <= 1'b0;
            aaah_gnd_q   <= 1'b0;
        end else begin
            ground_map_q <= ground_map_d;
            wall_map_q   <= wall_map_d;
            x_q          <= x_d;
            dig_cnt_q    <= dig_cnt_d;
            fall_cnt_q   <= fall_cnt_d;
            tiles_dug_q  <= tiles_dug_d;
            err_q        <= err_d;
            aaah_gnd_q   <= aaah_gnd_d;
        end
    end

endmodule
